// File: rtl/screen_fetch_arbiter_pkg.sv
// Shared definitions for the screen RAM fetch arbiter: widths, default screen base,
// state encoding and the screen cell address helper.
package screen_fetch_arbiter_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;

    localparam logic [ADDR_W-1:0] SCREEN_BASE_DEFAULT = 11'h200;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_ACC = 3'd1,
        ST_CPU_ACK = 3'd2,
        ST_FETCH   = 3'd3,
        ST_DRAIN   = 3'd4
    } arb_state_t;

    // Screen RAM address of cell (row, col); the add wraps naturally at 2048.
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col
    );
        return base + {1'b0, row, col};
    endfunction

endpackage

// File: rtl/screen_fetch_arbiter.sv
// Arbitrates the single screen RAM port between CPU accesses and video row fetches
// that fill the line buffer; video always has priority.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | port free; start a due fetch, else accept a CPU request
// CPU_ACC  | CPU RAM cycle on the port
// CPU_ACK  | cpu_ack pulse, read data returned; chain into a pending fetch
// FETCH    | 32 RAM reads of one pixel row, write-back trails by one cycle
// DRAIN    | final line buffer write of column 31
module screen_fetch_arbiter
    import screen_fetch_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SCREEN_BASE = SCREEN_BASE_DEFAULT,
    parameter int                ROW_CELLS   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [ROW_W-1:0]  fetch_row,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              lb_we,
    output logic [COL_W-1:0]  lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_busy,
    output logic              fetch_overrun
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_CELLS - 1);

    arb_state_t       state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             pend;
    logic [ROW_W-1:0] pend_row;
    logic             fetch_due;
    logic [ROW_W-1:0] start_row;

    // A latched request keeps its row; a simultaneous new pulse is the one dropped.
    always_comb begin
        fetch_due = pend | line_start;
        start_row = pend ? pend_row : fetch_row;
    end

    assign cpu_rdata = ram_rdata;
    assign lb_wdata  = ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cpu_ack       <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            lb_we         <= 1'b0;
            lb_waddr      <= '0;
            fetch_busy    <= 1'b0;
            fetch_overrun <= 1'b0;
            pend          <= 1'b0;
            pend_row      <= '0;
            row           <= '0;
            col           <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            lb_we   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (fetch_due) begin
                        if (pend && line_start) fetch_overrun <= 1'b1;
                        pend       <= 1'b0;
                        row        <= start_row;
                        col        <= '0;
                        ram_en     <= 1'b1;
                        ram_addr   <= cell_addr(SCREEN_BASE, start_row, COL_W'(0));
                        fetch_busy <= 1'b1;
                        state      <= ST_FETCH;
                    end else if (cpu_req) begin
                        ram_en    <= 1'b1;
                        ram_we    <= cpu_we;
                        ram_addr  <= cpu_addr;
                        ram_wdata <= cpu_wdata;
                        state     <= ST_CPU_ACC;
                    end
                end

                ST_CPU_ACC: begin
                    if (line_start) begin
                        if (pend) begin
                            fetch_overrun <= 1'b1;
                        end else begin
                            pend     <= 1'b1;
                            pend_row <= fetch_row;
                        end
                    end
                    cpu_ack <= 1'b1;
                    state   <= ST_CPU_ACK;
                end

                ST_CPU_ACK: begin
                    if (fetch_due) begin
                        if (pend && line_start) fetch_overrun <= 1'b1;
                        pend       <= 1'b0;
                        row        <= start_row;
                        col        <= '0;
                        ram_en     <= 1'b1;
                        ram_addr   <= cell_addr(SCREEN_BASE, start_row, COL_W'(0));
                        fetch_busy <= 1'b1;
                        state      <= ST_FETCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    if (line_start) fetch_overrun <= 1'b1;
                    lb_we    <= 1'b1;
                    lb_waddr <= col;
                    if (col == LAST_COL) begin
                        state <= ST_DRAIN;
                    end else begin
                        col      <= col + 1'b1;
                        ram_en   <= 1'b1;
                        ram_addr <= cell_addr(SCREEN_BASE, row, col + 1'b1);
                    end
                end

                ST_DRAIN: begin
                    if (line_start) fetch_overrun <= 1'b1;
                    fetch_busy <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_fetch_arbiter.sv
// Bench for screen_fetch_arbiter: a timeline reservation model predicts every output
// cycle by cycle; directed scenarios pin the model with literal expectations.
module tb_screen_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [4:0]  fetch_row = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;

    logic        cpu_ack, ram_en, ram_we, lb_we, fetch_busy, fetch_overrun;
    logic [7:0]  cpu_rdata, ram_wdata, lb_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [10:0] ram_addr;
    logic [4:0]  lb_waddr;

    logic        cpu_ack_w, ram_en_w, ram_we_w, lb_we_w, fetch_busy_w, fetch_overrun_w;
    logic [7:0]  cpu_rdata_w, ram_wdata_w, lb_wdata_w;
    logic [10:0] ram_addr_w;
    logic [4:0]  lb_waddr_w;

    always #5 clk = ~clk;

    screen_fetch_arbiter dut (
        .clk(clk), .reset(reset), .line_start(line_start), .fetch_row(fetch_row),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
    );

    // Second instance with a high screen base to exercise address wrap; its RAM reads as zero.
    screen_fetch_arbiter #(.SCREEN_BASE(11'h7F0)) dut_w (
        .clk(clk), .reset(reset), .line_start(line_start), .fetch_row(fetch_row),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_w), .cpu_rdata(cpu_rdata_w), .ram_en(ram_en_w), .ram_we(ram_we_w),
        .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w), .ram_rdata(8'h00),
        .lb_we(lb_we_w), .lb_waddr(lb_waddr_w), .lb_wdata(lb_wdata_w),
        .fetch_busy(fetch_busy_w), .fetch_overrun(fetch_overrun_w)
    );

    logic [7:0] ram_mem [2048];
    logic [7:0] mmem    [2048];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: per-cycle reservations of the RAM port ----------------
    typedef struct packed {
        logic        en;
        logic        we;
        logic        fetch;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [4:0]  row;
        logic [4:0]  col;
    } ram_exp_t;

    ram_exp_t   ram_q [int];
    bit         lbw   [int];
    logic [4:0] lba   [int];
    logic [7:0] lbd   [int];
    bit         ackq  [int];
    bit         ack_rd[int];
    logic [7:0] ack_d [int];
    bit         busyq [int];

    int         free_at = 0;
    int         op = 0;        // 0 none, 1 cpu, 2 fetch
    int         op_start = 0;
    bit         m_pend = 1'b0;
    logic [4:0] m_prow = '0;
    bit         m_ovr = 1'b0;

    function automatic logic [10:0] fa(input int base, input int r, input int c);
        return 11'((base + 32 * r + c) % 2048);
    endfunction

    task automatic sched_fetch(input int d, input logic [4:0] r);
        ram_exp_t x;
        op = 2;
        op_start = d;
        free_at = d + 34;
        for (int c = 0; c < 32; c++) begin
            x = '0;
            x.en = 1'b1;
            x.fetch = 1'b1;
            x.row = r;
            x.col = 5'(c);
            x.addr = fa(32'h200, int'(r), c);
            ram_q[d + 1 + c] = x;
            lbw[d + 2 + c] = 1'b1;
            lba[d + 2 + c] = 5'(c);
            lbd[d + 2 + c] = mmem[x.addr];
        end
        for (int k = d + 1; k <= d + 33; k++) busyq[k] = 1'b1;
    endtask

    task automatic sched_cpu(input int d);
        ram_exp_t x;
        op = 1;
        op_start = d;
        free_at = d + 3;
        x = '0;
        x.en = 1'b1;
        x.we = cpu_we;
        x.addr = cpu_addr;
        x.wdata = cpu_wdata;
        ram_q[d + 1] = x;
        ackq[d + 2] = 1'b1;
        ack_rd[d + 2] = !cpu_we;
        ack_d[d + 2] = mmem[cpu_addr];
        if (cpu_we) mmem[cpu_addr] = cpu_wdata;
    endtask

    task automatic start_if_due(input int t, output bit started);
        logic [4:0] r;
        started = 1'b0;
        if (m_pend || line_start) begin
            if (m_pend && line_start) m_ovr = 1'b1;
            r = m_pend ? m_prow : fetch_row;
            m_pend = 1'b0;
            sched_fetch(t, r);
            started = 1'b1;
        end
    endtask

    task automatic model_step(input int t);
        bit started;
        if (reset) begin
            ram_q.delete(); lbw.delete(); lba.delete(); lbd.delete();
            ackq.delete(); ack_rd.delete(); ack_d.delete(); busyq.delete();
            m_pend = 1'b0;
            m_ovr = 1'b0;
            op = 0;
            free_at = t + 1;
            return;
        end
        if (t < free_at) begin
            if (op == 2) begin
                if (line_start) m_ovr = 1'b1;
            end else if (op == 1 && t == op_start + 1) begin
                if (line_start) begin
                    if (m_pend) m_ovr = 1'b1;
                    else begin
                        m_pend = 1'b1;
                        m_prow = fetch_row;
                    end
                end
            end else if (op == 1) begin
                start_if_due(t, started);
            end
        end else begin
            start_if_due(t, started);
            if (!started) begin
                if (cpu_req) sched_cpu(t);
                else free_at = t + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            ram_exp_t e;
            bit w, a;
            e = '0;
            if (ram_q.exists(cyc)) e = ram_q[cyc];
            chk("ram_en", ram_en, e.en);
            chk("ram_en_w", ram_en_w, e.en);
            if (e.en) begin
                chk("ram_we", ram_we, e.we);
                chk("ram_we_w", ram_we_w, e.we);
                chk("ram_addr", ram_addr, e.addr);
                chk("ram_addr_w", ram_addr_w,
                    e.fetch ? fa(32'h7F0, int'(e.row), int'(e.col)) : e.addr);
                if (e.we) begin
                    chk("ram_wdata", ram_wdata, e.wdata);
                    chk("ram_wdata_w", ram_wdata_w, e.wdata);
                end
            end
            w = lbw.exists(cyc);
            chk("lb_we", lb_we, w);
            chk("lb_we_w", lb_we_w, w);
            if (w) begin
                chk("lb_waddr", lb_waddr, lba[cyc]);
                chk("lb_waddr_w", lb_waddr_w, lba[cyc]);
                chk("lb_wdata", lb_wdata, lbd[cyc]);
                chk("lb_wdata_w", lb_wdata_w, 8'h00);
            end
            a = ackq.exists(cyc);
            chk("cpu_ack", cpu_ack, a);
            chk("cpu_ack_w", cpu_ack_w, a);
            if (a && ack_rd[cyc]) begin
                chk("cpu_rdata", cpu_rdata, ack_d[cyc]);
                chk("cpu_rdata_w", cpu_rdata_w, 8'h00);
            end
            chk("fetch_busy", fetch_busy, busyq.exists(cyc));
            chk("fetch_busy_w", fetch_busy_w, busyq.exists(cyc));
            chk("fetch_overrun", fetch_overrun, m_ovr);
            chk("fetch_overrun_w", fetch_overrun_w, m_ovr);
            ram_q.delete(cyc); lbw.delete(cyc); lba.delete(cyc); lbd.delete(cyc);
            ackq.delete(cyc); ack_rd.delete(cyc); ack_d.delete(cyc); busyq.delete(cyc);
            model_step(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input bit we, input logic [10:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int lat);
        int n;
        bit got;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        n = cyc;
        got = 1'b0;
        rd = '0;
        lat = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                rd = cpu_rdata;
                lat = cyc - n;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout @cycle %0d: actual=no ack required=ack", cyc);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog @cycle %0d: actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat, n, cnt, ackc;

        for (int i = 0; i < 2048; i++) begin
            ram_mem[i] = 8'(i);
            mmem[i] = 8'(i);
        end

        tick(); tick();
        mon_on = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_addr", ram_addr, 11'h000);
        chk("rst_fetch_busy", fetch_busy, 1'b0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_overrun", fetch_overrun, 1'b0);
        tick(); tick();

        // row 3 fetch from a RAM holding addr[7:0]
        line_start = 1'b1; fetch_row = 5'd3; n = cyc;
        tick();
        line_start = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            cnt += int'(fetch_busy);
            if (k == 1)  chk("row3_first_addr", ram_addr, 11'h260);
            if (k == 32) chk("row3_last_addr", ram_addr, 11'h27F);
            if (k == 2)  chk("row3_lb_col0", {lb_we, lb_waddr, lb_wdata}, {1'b1, 5'd0, 8'h60});
            if (k == 33) chk("row3_lb_col31", {lb_we, lb_waddr, lb_wdata}, {1'b1, 5'd31, 8'h7F});
        end
        chk("row3_busy_cycles", cnt, 33);
        tick();

        // address wrap with the 11'h7F0 base, row 31
        line_start = 1'b1; fetch_row = 5'd31;
        tick();
        line_start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1)  chk("wrap_first_addr", ram_addr_w, 11'h3D0);
            if (k == 32) chk("wrap_last_addr", ram_addr_w, 11'h3EF);
        end
        tick();

        // CPU write then read back
        cpu_access(1'b1, 11'h205, 8'hA5, rd, lat);
        chk("cpu_write_latency", lat, 2);
        cpu_access(1'b0, 11'h205, 8'h00, rd, lat);
        chk("cpu_read_latency", lat, 2);
        chk("cpu_read_data", rd, 8'hA5);
        tick();

        // simultaneous line_start and cpu_req: video first
        line_start = 1'b1; fetch_row = 5'd5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h210;
        n = cyc;
        tick();
        line_start = 1'b0;
        cnt = 0;
        ackc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ram_en && !fetch_busy) cnt++;
            if (cpu_ack) begin
                ackc = cyc;
                break;
            end
        end
        chk("contend_ack_cycle", ackc - n, 36);
        chk("contend_cpu_accesses", cnt, 1);
        tick();
        cpu_req = 1'b0;
        tick();

        // line_start during CPU_ACK chains straight into the fetch; a later one overruns
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
        tick();
        tick();
        line_start = 1'b1; fetch_row = 5'd7;
        @(negedge clk);
        chk("chain_ack", cpu_ack, 1'b1);
        tick();
        line_start = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("chain_busy", fetch_busy, 1'b1);
        chk("chain_addr", ram_addr, 11'h2E0);
        chk("chain_no_overrun", fetch_overrun, 1'b0);
        repeat (5) tick();
        line_start = 1'b1; fetch_row = 5'd9;
        tick();
        line_start = 1'b0;
        @(negedge clk);
        chk("overrun_set", fetch_overrun, 1'b1);
        repeat (40) tick();
        @(negedge clk);
        chk("overrun_sticky", fetch_overrun, 1'b1);
        chk("overrun_idle", fetch_busy, 1'b0);
        tick();

        // reset while reading column 10
        line_start = 1'b1; fetch_row = 5'd2;
        tick();
        line_start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ram_en", ram_en, 1'b0);
        chk("mid_rst_ram_addr", ram_addr, 11'h000);
        chk("mid_rst_lb_we", lb_we, 1'b0);
        chk("mid_rst_lb_waddr", lb_waddr, 5'd0);
        chk("mid_rst_busy", fetch_busy, 1'b0);
        chk("mid_rst_overrun", fetch_overrun, 1'b0);
        tick();
        line_start = 1'b1; fetch_row = 5'd4;
        tick();
        line_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cnt += int'(lb_we);
        end
        chk("post_rst_lb_writes", cnt, 32);
        tick();

        // randomized traffic
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    cpu_access(1'($urandom), 11'($urandom), 8'($urandom), rd, lat);
                end
            end
            begin
                repeat (2500) begin
                    line_start = ($urandom_range(0, 59) == 0);
                    fetch_row = 5'($urandom);
                    tick();
                end
                line_start = 1'b0;
            end
        join

        repeat (40) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
